// File: rtl/pattern_row_streamer.sv
// Streams one stored seed pattern row by row out of a 1-cycle-latency pattern memory.
// Each row is issued, captured, then held on a valid/ready handshake; one-shot or looping.
module pattern_row_streamer #(
  parameter int WIDTH  = 128,
  parameter int ROWS   = 32,
  parameter int NPAT   = 32,
  parameter int ADDR_W = 10,
  parameter int PSEL_W = 5,
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [PSEL_W-1:0] pattern_sel,
  input  logic              loop_mode,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic [WIDTH-1:0]  row_data,
  output logic [RIDX_W-1:0] row_idx,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROWS_A   = ADDR_W'(ROWS);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic                loop_reg, loop_next;
  logic [RIDX_W-1:0]   row_reg, row_next;
  logic [WIDTH-1:0]    data_reg;
  logic [RIDX_W-1:0]   idx_reg;
  logic                valid_reg, valid_next;
  logic                sel_err_reg, sel_err_next;
  logic                capture;
  logic                sel_ok;
  logic [ADDR_W-1:0]   sel_base;

  // Out-of-range selects never reach the multiplier result, so truncation there is harmless.
  assign sel_ok   = (32'(pattern_sel) < 32'(NPAT));
  assign sel_base = ADDR_W'(pattern_sel) * ROWS_A;

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    loop_next    = loop_reg;
    row_next     = row_reg;
    valid_next   = valid_reg;
    sel_err_next = 1'b0;
    capture      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (sel_ok) begin
            base_next  = sel_base;
            loop_next  = loop_mode;
            row_next   = '0;
            state_next = S_ISSUE;
          end else begin
            sel_err_next = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        capture    = 1'b1;
        valid_next = 1'b1;
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_reg && row_ready) begin
          valid_next = 1'b0;
          if (row_reg == LAST_ROW) begin
            row_next   = '0;
            state_next = loop_reg ? S_ISSUE : S_DONE;
          end else begin
            row_next   = row_reg + RIDX_W'(1);
            state_next = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        valid_next = 1'b0;
      end
    endcase

    // Abort wins over an accept in the same cycle; the presented row is simply dropped.
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      base_reg    <= '0;
      loop_reg    <= 1'b0;
      row_reg     <= '0;
      data_reg    <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      sel_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      loop_reg    <= loop_next;
      row_reg     <= row_next;
      valid_reg   <= valid_next;
      sel_err_reg <= sel_err_next;
      if (capture) begin
        data_reg <= mem_dout;
        idx_reg  <= row_reg;
      end
    end
  end

  // base + row stays within the selected pattern, so the address never wraps.
  assign mem_en    = (state_reg == S_ISSUE);
  assign mem_addr  = base_reg + ADDR_W'(row_reg);
  assign row_data  = data_reg;
  assign row_idx   = idx_reg;
  assign row_valid = valid_reg;
  assign busy      = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_PRESENT);
  assign done      = (state_reg == S_DONE);
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_pattern_row_streamer.sv
// Scoreboard bench: the stimulus side predicts addresses and rows from the pattern memory,
// independent monitors compare every memory read and every accepted row.
module tb_pattern_row_streamer;

  localparam int WIDTH  = 128;
  localparam int ROWS   = 32;
  localparam int NPAT   = 32;
  localparam int ADDR_W = 10;
  localparam int PSEL_W = 6;
  localparam int RIDX_W = 5;

  logic              clka = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PSEL_W-1:0] pattern_sel = '0;
  logic              loop_mode = 1'b0;
  logic              abort = 1'b0;
  logic              row_ready = 1'b0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_dout = '0;
  logic [WIDTH-1:0]  row_data;
  logic [RIDX_W-1:0] row_idx;
  logic              row_valid;
  logic              busy;
  logic              done;
  logic              sel_err;

  pattern_row_streamer #(
    .WIDTH (WIDTH),
    .ROWS  (ROWS),
    .NPAT  (NPAT),
    .ADDR_W(ADDR_W),
    .PSEL_W(PSEL_W)
  ) dut (
    .clka       (clka),
    .rst        (rst),
    .start      (start),
    .pattern_sel(pattern_sel),
    .loop_mode  (loop_mode),
    .abort      (abort),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .busy       (busy),
    .done       (done),
    .sel_err    (sel_err)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [WIDTH-1:0]  data;
    logic [RIDX_W-1:0] idx;
  } row_t;

  logic [WIDTH-1:0]  mem_arr [0:(1<<ADDR_W)-1];
  row_t              row_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int last_acc_cyc = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int hold_cnt = 0;

  // Pattern memory: one-cycle registered read.
  always @(posedge clka) begin
    if (mem_en) mem_dout <= mem_arr[mem_addr];
  end

  always @(posedge clka) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Reference model: a pass of n rows reads base+(k mod ROWS) and delivers that word with its row number.
  task automatic push_pass(input int sel, input int n);
    int r;
    int a;
    for (int k = 0; k < n; k++) begin
      r = k % ROWS;
      a = sel * ROWS + r;
      addr_q.push_back(ADDR_W'(a));
      row_q.push_back('{data: mem_arr[a], idx: RIDX_W'(r)});
    end
  endtask

  // Monitor: compares memory reads and accepted rows against the queues; checks hold stability.
  row_t              mon_exp;
  logic [ADDR_W-1:0] mon_addr;
  logic              hold_prev = 1'b0;
  logic [WIDTH-1:0]  held_data;
  logic [RIDX_W-1:0] held_idx;

  always @(negedge clka) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (mem_en) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_addr_unexpected: got %0h, expected no read", mem_addr);
        end else begin
          mon_addr = addr_q.pop_front();
          check("mem_addr", mem_addr, mon_addr);
        end
      end
      if (row_valid) check("mem_en_while_valid", mem_en, 1'b0);
      if (hold_prev && row_valid) begin
        check("held_row_data", row_data, held_data);
        check("held_row_idx", row_idx, held_idx);
      end
      hold_prev = row_valid && !row_ready && !abort;
      held_data = row_data;
      held_idx  = row_idx;
      if (row_valid && row_ready && !abort) begin
        if (row_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL row_unexpected: got idx %0d, expected no row", row_idx);
        end else begin
          mon_exp = row_q.pop_front();
          check("row_data", row_data, mon_exp.data);
          check("row_idx", row_idx, mon_exp.idx);
          last_acc_cyc = cyc_cnt;
        end
      end
      if (done) done_cnt++;
    end
  end

  // Ready driver: 0 always ready, 1 random, 2 stall row 7 for five cycles, other never ready.
  always @(posedge clka) begin
    #1;
    case (rdy_mode)
      0: row_ready = 1'b1;
      1: row_ready = 1'($urandom_range(0, 1));
      2: begin
        if (row_valid && row_idx == 5'd7 && hold_cnt < 5) begin
          row_ready = 1'b0;
          hold_cnt++;
        end else begin
          row_ready = 1'b1;
        end
      end
      default: row_ready = 1'b0;
    endcase
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_row_data"}, row_data, '0);
    check({tag, "_row_idx"}, row_idx, '0);
    check({tag, "_row_valid"}, row_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sel_err"}, sel_err, 1'b0);
  endtask

  task automatic start_pass(input int sel, input logic lp);
    pattern_sel = PSEL_W'(sel);
    loop_mode   = lp;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (!row_valid && c < 10) begin
      tick();
      c++;
    end
  endtask

  task automatic run_oneshot(input int sel);
    int c;
    bit got;
    push_pass(sel, ROWS);
    start_pass(sel, 1'b0);
    wait_valid(c);
    check("first_valid_latency", c, 3);
    // a start while busy, possibly with an illegal select, must be ignored
    pattern_sel = PSEL_W'($urandom_range(0, 63));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sel_err_while_busy", sel_err, 1'b0);
    check("busy_mid_pass", busy, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", got, 1'b1);
    if (got) begin
      check("done_after_last_accept", cyc_cnt, last_acc_cyc + 1);
      check("busy_in_done", busy, 1'b0);
      check("rows_drained", row_q.size(), 0);
      check("addrs_drained", addr_q.size(), 0);
      tick();
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
    end
    row_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d0;
    int sel;
    for (int i = 0; i < (1 << ADDR_W); i++)
      mem_arr[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // one-shot, pattern 3, always ready
    rdy_mode = 0;
    run_oneshot(3);

    // backpressure on row 7
    rdy_mode = 2;
    hold_cnt = 0;
    run_oneshot(int'($urandom_range(0, NPAT - 1)));
    check("stall_cycles", hold_cnt, 5);

    // loop mode, pattern 0: 40 rows then abort while the next read is in flight
    rdy_mode = 0;
    push_pass(0, 40);
    addr_q.push_back(ADDR_W'(40 % ROWS));
    d0 = done_cnt;
    start_pass(0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (row_q.size() == 0) break;
    end
    check("loop_rows_delivered", row_q.size(), 0);
    check("loop_issue_next", mem_en, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_row_valid", row_valid, 1'b0);
    check("abort_mem_en", mem_en, 1'b0);
    tick();
    tick();
    check("loop_addrs_drained", addr_q.size(), 0);
    check("loop_no_done", done_cnt, d0);
    row_q.delete();
    addr_q.delete();

    // illegal selects, and abort in IDLE
    for (int k = 0; k < 2; k++) begin
      start_pass((k == 0) ? 32 : 63, 1'b0);
      check("sel_err_pulse", sel_err, 1'b1);
      check("sel_err_busy", busy, 1'b0);
      tick();
      check("sel_err_one_cycle", sel_err, 1'b0);
      check("sel_err_idle", busy, 1'b0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_mem_en", mem_en, 1'b0);

    // last pattern reaches address 1023 without wrapping
    rdy_mode = 0;
    run_oneshot(31);

    // random patterns with random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) run_oneshot(int'($urandom_range(0, NPAT - 1)));

    // abort beats an accept presented in the same cycle
    rdy_mode = 0;
    sel = int'($urandom_range(0, NPAT - 1));
    push_pass(sel, ROWS);
    d0 = done_cnt;
    start_pass(sel, 1'b0);
    wait_valid(c);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_prio_valid", row_valid, 1'b0);
    check("abort_prio_busy", busy, 1'b0);
    check("abort_prio_no_accept", row_q.size(), ROWS);
    tick();
    check("abort_prio_addrs", addr_q.size(), ROWS - 1);
    check("abort_prio_no_done", done_cnt, d0);
    row_q.delete();
    addr_q.delete();

    // reset while a row is being presented
    rdy_mode = 3;
    sel = int'($urandom_range(0, NPAT - 1));
    push_pass(sel, ROWS);
    start_pass(sel, 1'b0);
    wait_valid(c);
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("reset_mid");
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_valid", row_valid, 1'b0);
    check("post_reset_addrs", addr_q.size(), ROWS - 1);
    row_q.delete();
    addr_q.delete();

    // recovers cleanly after reset
    rdy_mode = 0;
    run_oneshot(int'($urandom_range(0, NPAT - 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
